alu_cb_seq: RTL and testbench
=============================

# alu_cb_seq

Sequencer for CB-prefixed bit/shift instructions on the SM83 core. Accepts one decoded CB opcode, fetches the operand (register bus or memory at (HL)), drives the ALU through its load/execute phases for rotates, shifts and SWAP, and computes BIT/RES/SET internally. It sits directly upstream of the ALU and produces the writeback value plus the new Z/N/H/C flags for the register file and flag register.

## Interface
Parameters: none.

Ports:
- clk  in  1  core clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high; forces IDLE and all outputs to reset values
- req  in  1  request; sampled only in IDLE
- cb_op  in  8  CB opcode byte; captured on accept
- f_in  in  4  current flags {Z,N,H,C}; captured on accept
- bus_in  in  8  register operand (valid on accept cycle when cb_op[2:0]!=6) or memory read data (valid with mem_valid)
- mem_valid  in  1  memory read data valid
- mem_ack  in  1  memory write accepted
- alu_result  in  8  ALU result during EXEC
- alu_carry  in  1  ALU carry during EXEC
- busy  out  1  high in every state except IDLE
- alu_op  out  8  operand to ALU operand bus; held captured operand
- alu_ld  out  1  ALU load strobe (operand into B, zero into A)
- alu_oe_res  out  1  ALU result output enable
- alu_sh  out  3  shift kind = cb_op[5:3] (0 RLC,1 RRC,2 RL,3 RR,4 SLA,5 SRA,6 SWAP,7 SRL)
- alu_ci  out  1  carry-in to ALU
- mem_rd  out  1  memory read request
- mem_we  out  1  memory write request
- mem_wdata  out  8  memory write data
- done  out  1  one-cycle completion pulse
- wb_en  out  1  register writeback enable, valid with done
- result_out  out  8  writeback value
- flags_out  out  4  new {Z,N,H,C}

## Operation
- States: IDLE, MRD, LOAD, EXEC, MWR, DONE.
- IDLE: req=1 accepts: capture cb_op, f_in; if cb_op[2:0]!=6 capture bus_in as operand. Next: MRD if cb_op[2:0]==6, else LOAD.
- MRD: mem_rd=1; on mem_valid capture bus_in as operand, go LOAD; otherwise stay (no timeout).
- LOAD: if cb_op[7:6]==0: alu_ld=1, alu_op=operand; else idle cycle (internal compute). Next EXEC.
- EXEC: rows 0x00-0x3F: alu_oe_res=1, capture alu_result, alu_carry. Rows 0x40-0xFF: compute internally with n=cb_op[5:3]:
  - BIT: no result; Z=~operand[n], N=0, H=1, C=f C.
  - RES: result=operand & ~(1<<n); flags = captured f_in.
  - SET: result=operand | (1<<n); flags = captured f_in.
  - Shift rows: Z=(result==0), N=0, H=0, C=alu_carry (SWAP: C=0 regardless of ALU).
  - Next: MWR if (HL) and not BIT, else DONE.
- MWR: mem_we=1, mem_wdata=result; stay until mem_ack, then DONE.
- DONE: done=1; wb_en=1 iff register target and not BIT; next IDLE.
- alu_ci = captured C for RL/RR, 0 for all other ops; alu_sh = captured cb_op[5:3] in all states.
- result_out/flags_out registered; update only on entering DONE; hold until next DONE.

## Timing
- Reset values: state IDLE, busy 0, done 0, wb_en 0, alu_ld 0, alu_oe_res 0, mem_rd 0, mem_we 0, alu_ci 0, alu_sh 0, alu_op 0, mem_wdata 0, result_out 0, flags_out 0.
- Control outputs (busy, alu_ld, alu_oe_res, mem_rd, mem_we, done, wb_en) are Moore, decoded from state.
- Register target: accept at edge N; LOAD in N+1, EXEC N+2, DONE (done=1) N+3; busy high N+1..N+3; req accepted again at edge N+4.
- (HL) target: +1 cycle per MRD cycle before mem_valid is seen, MRD is at least 1 cycle; MWR at least 1 cycle.
- req while busy: ignored, no queuing; req held high in DONE is accepted on the first IDLE cycle.
- mem_valid outside MRD, mem_ack outside MWR: ignored.
- reset mid-operation: immediate return to IDLE; no done, wb_en, or mem_we after release; result_out/flags_out cleared.

## Test plan
- SWAP B: cb_op=0x30, bus_in=0xA5, alu_result=0x5A, alu_carry=1 -> alu_ld in cycle 1 with alu_op=0xA5, alu_sh=6; done at cycle 3, result_out=0x5A, flags_out=4'b0000, wb_en=1.
- RL C with C set: cb_op=0x11, f_in=4'b0001, bus_in=0x80, alu_result=0x01, alu_carry=1 -> alu_ci=1, flags_out=4'b0001, result_out=0x01.
- BIT 7,B: cb_op=0x78, f_in=4'b0001, bus_in=0x7F -> flags_out=4'b1011, wb_en=0, alu_ld never asserted.
- SET 0,(HL): cb_op=0xC6, mem_valid after 2 MRD cycles with bus_in=0x10, mem_ack after 3 MWR cycles -> mem_wdata=0x11 with mem_we held until mem_ack, then done, wb_en=0, flags_out=f_in.
- Busy/reset: req pulsed during EXEC is ignored (exactly one done); reset asserted in MWR -> mem_we drops immediately, no done, busy=0.

Source files
------------

// File: rtl/alu_cb_seq_if.sv
// Handshake/bus bundle between the CB sequencer and its
// surroundings: request, memory port, ALU port, writeback.
interface alu_cb_seq_if;
  logic       req;
  logic [7:0] cb_op;
  logic [3:0] f_in;
  logic [7:0] bus_in;
  logic       mem_valid;
  logic       mem_ack;
  logic [7:0] alu_result;
  logic       alu_carry;
  logic       busy;
  logic [7:0] alu_op;
  logic       alu_ld;
  logic       alu_oe_res;
  logic [2:0] alu_sh;
  logic       alu_ci;
  logic       mem_rd;
  logic       mem_we;
  logic [7:0] mem_wdata;
  logic       done;
  logic       wb_en;
  logic [7:0] result_out;
  logic [3:0] flags_out;

  modport slave (
    input  req, cb_op, f_in, bus_in,
    input  mem_valid, mem_ack,
    input  alu_result, alu_carry,
    output busy, alu_op, alu_ld,
    output alu_oe_res, alu_sh, alu_ci,
    output mem_rd, mem_we, mem_wdata,
    output done, wb_en,
    output result_out, flags_out
  );

  modport master (
    output req, cb_op, f_in, bus_in,
    output mem_valid, mem_ack,
    output alu_result, alu_carry,
    input  busy, alu_op, alu_ld,
    input  alu_oe_res, alu_sh, alu_ci,
    input  mem_rd, mem_we, mem_wdata,
    input  done, wb_en,
    input  result_out, flags_out
  );
endinterface

// File: rtl/alu_cb_seq.sv
// SM83 CB-prefix sequencer: operand fetch, ALU shift drive,
// internal BIT/RES/SET, memory writeback and flag result.
module alu_cb_seq (
  input  logic         clk,
  input  logic         reset,
  alu_cb_seq_if.slave  sb
);

  typedef enum logic [2:0] {
    IDLE, MRD, LOAD, EXEC, MWR, DONE
  } state_t;

  state_t     r_state, w_nxt;
  logic [7:0] r_op;
  logic [3:0] r_f;
  logic [7:0] r_opnd;
  logic [7:0] r_res;
  logic [3:0] r_flg;
  logic [7:0] r_result;
  logic [3:0] r_flags;

  logic [1:0] w_row;
  logic [2:0] w_n;
  logic       w_hl;
  logic       w_bit;
  logic [7:0] w_mask;
  logic [7:0] w_res;
  logic [3:0] w_flg;

  assign w_row  = r_op[7:6];
  assign w_n    = r_op[5:3];
  assign w_hl   = (r_op[2:0] == 3'd6);
  assign w_bit  = (w_row == 2'd1);
  assign w_mask = 8'h01 << w_n;

  always_comb begin
    w_res = r_opnd;
    w_flg = r_f;
    unique case (w_row)
      2'd0: begin
        w_res = sb.alu_result;
        // SWAP never produces a carry, whatever the ALU reports
        w_flg = {sb.alu_result == 8'h00, 2'b00,
                 (w_n == 3'd6) ? 1'b0 : sb.alu_carry};
      end
      2'd1: w_flg = {~r_opnd[w_n], 1'b0, 1'b1, r_f[0]};
      2'd2: w_res = r_opnd & ~w_mask;
      default: w_res = r_opnd | w_mask;
    endcase
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      IDLE:
        if (sb.req)
          w_nxt = (sb.cb_op[2:0] == 3'd6) ? MRD : LOAD;
      MRD:  if (sb.mem_valid) w_nxt = LOAD;
      LOAD: w_nxt = EXEC;
      EXEC: w_nxt = (w_hl && !w_bit) ? MWR : DONE;
      MWR:  if (sb.mem_ack) w_nxt = DONE;
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_op     <= 8'h00;
      r_f      <= 4'h0;
      r_opnd   <= 8'h00;
      r_res    <= 8'h00;
      r_flg    <= 4'h0;
      r_result <= 8'h00;
      r_flags  <= 4'h0;
    end else begin
      r_state <= w_nxt;
      if (r_state == IDLE && sb.req) begin
        r_op <= sb.cb_op;
        r_f  <= sb.f_in;
        if (sb.cb_op[2:0] != 3'd6)
          r_opnd <= sb.bus_in;
      end
      if (r_state == MRD && sb.mem_valid)
        r_opnd <= sb.bus_in;
      if (r_state == EXEC) begin
        r_res <= w_res;
        r_flg <= w_flg;
      end
      if (w_nxt == DONE && r_state != DONE) begin
        r_result <= (r_state == EXEC) ? w_res : r_res;
        r_flags  <= (r_state == EXEC) ? w_flg : r_flg;
      end
    end
  end

  assign sb.busy       = (r_state != IDLE);
  assign sb.alu_ld     = (r_state == LOAD) && (w_row == 2'd0);
  assign sb.alu_oe_res = (r_state == EXEC) && (w_row == 2'd0);
  assign sb.mem_rd     = (r_state == MRD);
  assign sb.mem_we     = (r_state == MWR);
  assign sb.done       = (r_state == DONE);
  assign sb.wb_en      = (r_state == DONE) && !w_hl && !w_bit;
  assign sb.alu_op     = r_opnd;
  assign sb.alu_sh     = w_n;
  assign sb.alu_ci     = (w_row == 2'd0) &&
                         (w_n == 3'd2 || w_n == 3'd3) && r_f[0];
  assign sb.mem_wdata  = r_res;
  assign sb.result_out = r_result;
  assign sb.flags_out  = r_flags;

endmodule

// File: tb/tb_alu_cb_seq.sv
// Directed bench for alu_cb_seq: register, (HL), BIT/RES/SET,
// busy-while-running and mid-operation reset.
module tb_alu_cb_seq;

  logic clk = 1'b0;
  logic reset;
  int   nvec = 0;
  int   nfail = 0;
  int   ndone = 0;

  alu_cb_seq_if bus ();

  alu_cb_seq u_dut (
    .clk   (clk),
    .reset (reset),
    .sb    (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.done) ndone++;

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int d0;
    reset          = 1'b1;
    bus.req        = 1'b0;
    bus.cb_op      = 8'h00;
    bus.f_in       = 4'h0;
    bus.bus_in     = 8'h00;
    bus.mem_valid  = 1'b0;
    bus.mem_ack    = 1'b0;
    bus.alu_result = 8'h00;
    bus.alu_carry  = 1'b0;
    step();
    step();
    chk("rst_busy", 8'(bus.busy), 8'h0);
    chk("rst_done", 8'(bus.done), 8'h0);
    chk("rst_wb", 8'(bus.wb_en), 8'h0);
    chk("rst_memwe", 8'(bus.mem_we), 8'h0);
    chk("rst_res", bus.result_out, 8'h00);
    chk("rst_flg", 8'(bus.flags_out), 8'h0);
    chk("rst_aluop", bus.alu_op, 8'h00);
    chk("rst_alush", 8'(bus.alu_sh), 8'h0);
    reset = 1'b0;
    step();

    // SWAP B
    bus.req = 1'b1; bus.cb_op = 8'h30; bus.f_in = 4'b0001;
    bus.bus_in = 8'hA5;
    bus.alu_result = 8'h5A; bus.alu_carry = 1'b1;
    step();
    bus.req = 1'b0;
    chk("swap_busy", 8'(bus.busy), 8'h1);
    chk("swap_ld", 8'(bus.alu_ld), 8'h1);
    chk("swap_aluop", bus.alu_op, 8'hA5);
    chk("swap_sh", 8'(bus.alu_sh), 8'h6);
    chk("swap_ci", 8'(bus.alu_ci), 8'h0);
    step();
    chk("swap_oe", 8'(bus.alu_oe_res), 8'h1);
    chk("swap_ld2", 8'(bus.alu_ld), 8'h0);
    step();
    chk("swap_done", 8'(bus.done), 8'h1);
    chk("swap_wb", 8'(bus.wb_en), 8'h1);
    chk("swap_res", bus.result_out, 8'h5A);
    chk("swap_flg", 8'(bus.flags_out), 8'h0);
    step();
    chk("swap_idle", 8'(bus.busy), 8'h0);
    chk("swap_hold", bus.result_out, 8'h5A);

    // RL C with carry set
    bus.req = 1'b1; bus.cb_op = 8'h11; bus.f_in = 4'b0001;
    bus.bus_in = 8'h80;
    bus.alu_result = 8'h01; bus.alu_carry = 1'b1;
    step();
    bus.req = 1'b0;
    chk("rl_ci", 8'(bus.alu_ci), 8'h1);
    chk("rl_sh", 8'(bus.alu_sh), 8'h2);
    step();
    step();
    chk("rl_done", 8'(bus.done), 8'h1);
    chk("rl_res", bus.result_out, 8'h01);
    chk("rl_flg", 8'(bus.flags_out), 8'h1);
    step();

    // SRL A giving zero result
    bus.req = 1'b1; bus.cb_op = 8'h3F; bus.f_in = 4'b0001;
    bus.bus_in = 8'h01;
    bus.alu_result = 8'h00; bus.alu_carry = 1'b1;
    step();
    bus.req = 1'b0;
    chk("srl_ci", 8'(bus.alu_ci), 8'h0);
    step();
    step();
    chk("srl_res", bus.result_out, 8'h00);
    chk("srl_flg", 8'(bus.flags_out), 8'h9);
    step();

    // BIT 7,B
    bus.req = 1'b1; bus.cb_op = 8'h78; bus.f_in = 4'b0001;
    bus.bus_in = 8'h7F;
    step();
    bus.req = 1'b0;
    chk("bit_ld", 8'(bus.alu_ld), 8'h0);
    step();
    chk("bit_oe", 8'(bus.alu_oe_res), 8'h0);
    step();
    chk("bit_done", 8'(bus.done), 8'h1);
    chk("bit_wb", 8'(bus.wb_en), 8'h0);
    chk("bit_flg", 8'(bus.flags_out), 8'hB);
    step();

    // RES 3,D
    bus.req = 1'b1; bus.cb_op = 8'h9A; bus.f_in = 4'b1010;
    bus.bus_in = 8'hFF;
    step();
    bus.req = 1'b0;
    step();
    step();
    chk("res_wb", 8'(bus.wb_en), 8'h1);
    chk("res_res", bus.result_out, 8'hF7);
    chk("res_flg", 8'(bus.flags_out), 8'hA);
    step();

    // SET 0,(HL)
    bus.req = 1'b1; bus.cb_op = 8'hC6; bus.f_in = 4'b0110;
    bus.bus_in = 8'hEE;
    step();
    bus.req = 1'b0;
    chk("set_rd1", 8'(bus.mem_rd), 8'h1);
    step();
    chk("set_rd2", 8'(bus.mem_rd), 8'h1);
    step();
    chk("set_rd3", 8'(bus.mem_rd), 8'h1);
    bus.mem_valid = 1'b1; bus.bus_in = 8'h10;
    step();
    bus.mem_valid = 1'b0;
    chk("set_load_rd", 8'(bus.mem_rd), 8'h0);
    chk("set_ld", 8'(bus.alu_ld), 8'h0);
    step();
    step();
    chk("set_we1", 8'(bus.mem_we), 8'h1);
    chk("set_wdata", bus.mem_wdata, 8'h11);
    step();
    chk("set_we2", 8'(bus.mem_we), 8'h1);
    step();
    chk("set_we3", 8'(bus.mem_we), 8'h1);
    bus.mem_ack = 1'b1;
    step();
    bus.mem_ack = 1'b0;
    chk("set_done", 8'(bus.done), 8'h1);
    chk("set_we_off", 8'(bus.mem_we), 8'h0);
    chk("set_wb", 8'(bus.wb_en), 8'h0);
    chk("set_res", bus.result_out, 8'h11);
    chk("set_flg", 8'(bus.flags_out), 8'h6);
    step();

    // req pulsed during EXEC is ignored
    d0 = ndone;
    bus.req = 1'b1; bus.cb_op = 8'h00; bus.f_in = 4'b0000;
    bus.bus_in = 8'h01;
    bus.alu_result = 8'h02; bus.alu_carry = 1'b0;
    step();
    bus.req = 1'b0;
    step();
    bus.req = 1'b1;
    step();
    bus.req = 1'b0;
    chk("rlc_res", bus.result_out, 8'h02);
    for (int i = 0; i < 6; i++) step();
    chk("busy_ndone", 8'(ndone - d0), 8'h1);
    chk("busy_idle", 8'(bus.busy), 8'h0);

    // reset during MWR
    bus.req = 1'b1; bus.cb_op = 8'hCE; bus.f_in = 4'b0000;
    bus.mem_valid = 1'b1; bus.bus_in = 8'h00;
    step();
    bus.req = 1'b0;
    step();
    bus.mem_valid = 1'b0;
    step();
    step();
    chk("rst_mwr_we", 8'(bus.mem_we), 8'h1);
    chk("rst_mwr_wd", bus.mem_wdata, 8'h02);
    d0 = ndone;
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_we", 8'(bus.mem_we), 8'h0);
    chk("rst_mid_busy", 8'(bus.busy), 8'h0);
    chk("rst_mid_res", bus.result_out, 8'h00);
    step();
    reset = 1'b0;
    bus.mem_ack = 1'b1;
    for (int i = 0; i < 4; i++) step();
    bus.mem_ack = 1'b0;
    chk("rst_mid_ndone", 8'(ndone - d0), 8'h0);
    chk("rst_mid_we2", 8'(bus.mem_we), 8'h0);
    chk("rst_mid_wb", 8'(bus.wb_en), 8'h0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nfail);
    $finish;
  end

endmodule
